tmu2_decay_sched: RTL and testbench

TMU2_DECAY_SCHED -- requirements
Module: tmu2_decay_sched

---
 rtl/tmu2_decay_sched_pkg.sv | 19 +
 rtl/tmu2_decay_sched_fade.sv | 35 +++
 rtl/tmu2_decay_sched.sv | 142 ++++++++++++++
 tb/tb_tmu2_decay_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmu2_decay_sched_pkg.sv
// rtl/tmu2_decay_sched_pkg.sv - shared state encoding, widths and fade arithmetic for the decay scheduler
package tmu2_decay_sched_pkg;

  localparam int BRIGHT_W = 6;
  localparam int COLOR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Fade subtraction clamps at zero so a dimming sequence never wraps to full brightness.
  function automatic logic [BRIGHT_W-1:0] sat_sub(input logic [BRIGHT_W-1:0] a,
                                                  input logic [BRIGHT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/tmu2_decay_sched_fade.sv
// rtl/tmu2_decay_sched_fade.sv - fade_level register with saturating step-down, used under TMU2_DECAY_SCHED_FADE_EN
module tmu2_decay_sched_fade
  import tmu2_decay_sched_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                load,
  input  logic [BRIGHT_W-1:0] load_val,
  input  logic                step_en,
  input  logic [BRIGHT_W-1:0] fade_step,
  output logic [BRIGHT_W-1:0] fade_level
);

  logic [BRIGHT_W-1:0] fade_level_q, fade_level_d;

  always_comb begin
    fade_level_d = fade_level_q;
    if (load) begin
      fade_level_d = load_val;
    end else if (step_en) begin
      fade_level_d = sat_sub(fade_level_q, fade_step);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fade_level_q <= '0;
    end else begin
      fade_level_q <= fade_level_d;
    end
  end

  assign fade_level = fade_level_q;

endmodule

// File: rtl/tmu2_decay_sched.sv
// rtl/tmu2_decay_sched.sv - frame scheduler gating pixels into the decay stage; TMU2_DECAY_SCHED_FADE_EN adds auto-fade
module tmu2_decay_sched
  import tmu2_decay_sched_pkg::*;
#(
  parameter int npix_width = 22
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [npix_width-1:0] npixels,
  input  logic [BRIGHT_W-1:0]   brightness_cfg,
  input  logic                  chroma_key_en_cfg,
  input  logic [COLOR_W-1:0]    chroma_key_cfg,
`ifdef TMU2_DECAY_SCHED_FADE_EN
  input  logic                  fade_en,
  input  logic [BRIGHT_W-1:0]   fade_step,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [BRIGHT_W-1:0]   brightness,
  output logic                  chroma_key_en,
  output logic [COLOR_W-1:0]    chroma_key,
  input  logic                  src_stb_i,
  output logic                  src_ack_o,
  output logic                  dec_stb_o,
  input  logic                  dec_ack_i,
  input  logic                  dec_busy
);

  state_e                state_q, state_d;
  logic [npix_width-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic                  ck_en_q, ck_en_d;
  logic [COLOR_W-1:0]    ck_q, ck_d;

  logic                  gate_open;
  logic                  xfer;
  logic                  accept_start;
  logic [BRIGHT_W-1:0]   bright_src;

  // The gate is pure wiring in RUN, so the pixel path sees no added latency.
  assign gate_open = (state_q == ST_RUN);
  assign xfer      = gate_open & src_stb_i & dec_ack_i;
  assign dec_stb_o = gate_open & src_stb_i;
  assign src_ack_o = gate_open & dec_ack_i;

`ifdef TMU2_DECAY_SCHED_FADE_EN
  logic [BRIGHT_W-1:0] fade_level;

  tmu2_decay_sched_fade u_fade (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .load       (accept_start & ~fade_en),
    .load_val   (brightness_cfg),
    .step_en    (done_d & fade_en),
    .fade_step  (fade_step),
    .fade_level (fade_level)
  );

  assign bright_src = fade_en ? fade_level : brightness_cfg;
`else
  assign bright_src = brightness_cfg;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    bright_d     = bright_q;
    ck_en_d      = ck_en_q;
    ck_d         = ck_q;
    accept_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (npixels != '0) begin
            accept_start = 1'b1;
            cnt_d        = npixels;
            state_d      = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Abort discards the remaining count even if a pixel moves this cycle.
        if (abort) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (xfer) begin
          cnt_d = cnt_q - npix_width'(1);
          if (cnt_q == npix_width'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!dec_busy) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_start) begin
      bright_d = bright_src;
      ck_en_d  = chroma_key_en_cfg;
      ck_d     = chroma_key_cfg;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      bright_q <= '0;
      ck_en_q  <= 1'b0;
      ck_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      bright_q <= bright_d;
      ck_en_q  <= ck_en_d;
      ck_q     <= ck_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign brightness    = bright_q;
  assign chroma_key_en = ck_en_q;
  assign chroma_key    = ck_q;

endmodule

// File: tb/tb_tmu2_decay_sched.sv
// tb/tb_tmu2_decay_sched.sv - directed self-checking bench for tmu2_decay_sched (fade frames when TMU2_DECAY_SCHED_FADE_EN)
module tb_tmu2_decay_sched;

  localparam int NPW = 22;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           start;
  logic           abort;
  logic [NPW-1:0] npixels;
  logic [5:0]     brightness_cfg;
  logic           chroma_key_en_cfg;
  logic [15:0]    chroma_key_cfg;
`ifdef TMU2_DECAY_SCHED_FADE_EN
  logic           fade_en;
  logic [5:0]     fade_step;
`endif
  logic           busy;
  logic           done;
  logic [5:0]     brightness;
  logic           chroma_key_en;
  logic [15:0]    chroma_key;
  logic           src_stb_i;
  logic           src_ack_o;
  logic           dec_stb_o;
  logic           dec_ack_i;
  logic           dec_busy;

  int n_chk  = 0;
  int n_pass = 0;
  int xf;
  logic [4:0] pat;

  tmu2_decay_sched #(.npix_width(NPW)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .start             (start),
    .abort             (abort),
    .npixels           (npixels),
    .brightness_cfg    (brightness_cfg),
    .chroma_key_en_cfg (chroma_key_en_cfg),
    .chroma_key_cfg    (chroma_key_cfg),
`ifdef TMU2_DECAY_SCHED_FADE_EN
    .fade_en           (fade_en),
    .fade_step         (fade_step),
`endif
    .busy              (busy),
    .done              (done),
    .brightness        (brightness),
    .chroma_key_en     (chroma_key_en),
    .chroma_key        (chroma_key),
    .src_stb_i         (src_stb_i),
    .src_ack_o         (src_ack_o),
    .dec_stb_o         (dec_stb_o),
    .dec_ack_i         (dec_ack_i),
    .dec_busy          (dec_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

`ifdef TMU2_DECAY_SCHED_FADE_EN
  task automatic fade_frame(input logic fe, input logic [5:0] exp_b, input string tag);
    logic seen;
    fade_en   = fe;
    npixels   = NPW'(2);
    src_stb_i = 1'b1;
    dec_ack_i = 1'b1;
    dec_busy  = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_bright"}, 32'(brightness), 32'(exp_b));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sys_rst           = 1'b1;
    start             = 1'b0;
    abort             = 1'b0;
    npixels           = '0;
    brightness_cfg    = '0;
    chroma_key_en_cfg = 1'b0;
    chroma_key_cfg    = '0;
    src_stb_i         = 1'b0;
    dec_ack_i         = 1'b0;
    dec_busy          = 1'b0;
`ifdef TMU2_DECAY_SCHED_FADE_EN
    fade_en           = 1'b0;
    fade_step         = 6'd4;
`endif
    #12;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_bright", 32'(brightness), 32'd0);
    chk("rst_cken",   32'(chroma_key_en), 32'd0);
    chk("rst_ck",     32'(chroma_key), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();

    // Four-pixel frame with config changed after start to prove shadowing
    npixels           = NPW'(4);
    brightness_cfg    = 6'd32;
    chroma_key_en_cfg = 1'b1;
    chroma_key_cfg    = 16'hF81F;
    src_stb_i         = 1'b1;
    dec_ack_i         = 1'b1;
    dec_busy          = 1'b1;
    #1;
    chk("idle_stb", 32'(dec_stb_o), 32'd0);
    chk("idle_ack", 32'(src_ack_o), 32'd0);
    start = 1'b1;
    tick();
    start             = 1'b0;
    brightness_cfg    = 6'd5;
    chroma_key_en_cfg = 1'b0;
    chroma_key_cfg    = 16'h0000;
    chk("t1_busy",   32'(busy), 32'd1);
    chk("t1_bright", 32'(brightness), 32'd32);
    xf = 0;
    for (int i = 0; i < 8; i++) begin
      if (src_ack_o && dec_stb_o) xf++;
      tick();
    end
    chk("t1_xfers",       32'(xf), 32'd4);
    chk("t1_drain_busy",  32'(busy), 32'd1);
    chk("t1_drain_ack",   32'(src_ack_o), 32'd0);
    chk("t1_drain_stb",   32'(dec_stb_o), 32'd0);
    chk("t1_drain_done",  32'(done), 32'd0);
    chk("t1_drain_bright",32'(brightness), 32'd32);
    chk("t1_cken",        32'(chroma_key_en), 32'd1);
    chk("t1_ck",          32'(chroma_key), 32'hF81F);
    dec_busy = 1'b0;
    tick();
    chk("t1_done",      32'(done), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_done_clr",  32'(done), 32'd0);
    chk("t1_bright_end",32'(brightness), 32'd32);

    // Three-pixel frame with stalling ack
    npixels           = NPW'(3);
    brightness_cfg    = 6'd7;
    chroma_key_en_cfg = 1'b0;
    chroma_key_cfg    = 16'h07E0;
    src_stb_i         = 1'b1;
    dec_ack_i         = 1'b1;
    dec_busy          = 1'b0;
    start             = 1'b1;
    tick();
    start = 1'b0;
    pat   = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      dec_ack_i = pat[i];
      #1;
      chk($sformatf("t2_ack%0d", i), 32'(src_ack_o), 32'(pat[i]));
      tick();
    end
    dec_ack_i = 1'b1;
    #1;
    chk("t2_drain_ack",  32'(src_ack_o), 32'd0);
    chk("t2_drain_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_done",   32'(done), 32'd1);
    chk("t2_bright", 32'(brightness), 32'd7);
    tick();
    chk("t2_done_clr", 32'(done), 32'd0);

    // Zero-length frame
    brightness_cfg    = 6'd63;
    chroma_key_en_cfg = 1'b1;
    chroma_key_cfg    = 16'hFFFF;
    npixels           = '0;
    start             = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_done",   32'(done), 32'd1);
    chk("t3_busy",   32'(busy), 32'd0);
    chk("t3_bright", 32'(brightness), 32'd7);
    chk("t3_cken",   32'(chroma_key_en), 32'd0);
    chk("t3_ck",     32'(chroma_key), 32'h07E0);
    tick();
    chk("t3_done_clr", 32'(done), 32'd0);
    chk("t3_busy2",    32'(busy), 32'd0);

    // Abort after two of ten, start during DRAIN ignored
    npixels           = NPW'(10);
    brightness_cfg    = 6'd12;
    chroma_key_en_cfg = 1'b0;
    chroma_key_cfg    = 16'h1234;
    src_stb_i         = 1'b1;
    dec_ack_i         = 1'b1;
    dec_busy          = 1'b1;
    start             = 1'b1;
    tick();
    start = 1'b0;
    xf = 0;
    for (int i = 0; i < 2; i++) begin
      if (src_ack_o) xf++;
      tick();
    end
    chk("t4_acks", 32'(xf), 32'd2);
    src_stb_i = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    src_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start          = 1'b1;
        npixels        = NPW'(5);
        brightness_cfg = 6'd20;
      end
      #1;
      chk($sformatf("t4_drain_ack%0d", i),  32'(src_ack_o), 32'd0);
      chk($sformatf("t4_drain_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("t4_drain_done%0d", i), 32'(done), 32'd0);
      tick();
      start = 1'b0;
    end
    dec_busy = 1'b0;
    tick();
    chk("t4_done",   32'(done), 32'd1);
    chk("t4_busy",   32'(busy), 32'd0);
    chk("t4_bright", 32'(brightness), 32'd12);
    chk("t4_ck",     32'(chroma_key), 32'h1234);
    tick();
    chk("t4_not_queued", 32'(busy), 32'd0);
    chk("t4_done_clr",   32'(done), 32'd0);

    // Asynchronous reset mid-RUN with five pixels left
    npixels           = NPW'(8);
    brightness_cfg    = 6'd9;
    chroma_key_en_cfg = 1'b1;
    chroma_key_cfg    = 16'hABCD;
    src_stb_i         = 1'b1;
    dec_ack_i         = 1'b1;
    dec_busy          = 1'b1;
    start             = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("t5_busy",   32'(busy), 32'd0);
    chk("t5_bright", 32'(brightness), 32'd0);
    chk("t5_cken",   32'(chroma_key_en), 32'd0);
    chk("t5_ck",     32'(chroma_key), 32'd0);
    chk("t5_ack",    32'(src_ack_o), 32'd0);
    chk("t5_stb",    32'(dec_stb_o), 32'd0);
    tick();
    tick();
    chk("t5_done_rst", 32'(done), 32'd0);
    sys_rst  = 1'b0;
    dec_busy = 1'b0;
    tick();
    chk("t5_done_after", 32'(done), 32'd0);
    chk("t5_busy_after", 32'(busy), 32'd0);

    // Abort alone in IDLE ignored; start beats abort; single-pixel frame
    npixels        = NPW'(1);
    brightness_cfg = 6'd3;
    src_stb_i      = 1'b0;
    dec_ack_i      = 1'b1;
    dec_busy       = 1'b0;
    abort          = 1'b1;
    tick();
    chk("t6_abort_idle", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_start_wins", 32'(busy), 32'd1);
    chk("t6_bright",     32'(brightness), 32'd3);
    chk("t6_run_ack",    32'(src_ack_o), 32'd1);
    chk("t6_run_stb",    32'(dec_stb_o), 32'd0);
    src_stb_i = 1'b1;
    tick();
    chk("t6_drain_ack",  32'(src_ack_o), 32'd0);
    chk("t6_drain_busy", 32'(busy), 32'd1);
    tick();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();

`ifdef TMU2_DECAY_SCHED_FADE_EN
    fade_step      = 6'd4;
    brightness_cfg = 6'd10;
    fade_frame(1'b0, 6'd10, "f0");
    brightness_cfg = 6'd50;
    fade_frame(1'b1, 6'd10, "f1");
    fade_frame(1'b1, 6'd6,  "f2");
    fade_frame(1'b1, 6'd2,  "f3");
    fade_frame(1'b1, 6'd0,  "f4");
    fade_frame(1'b1, 6'd0,  "f5");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
